// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and header field layout for the program loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_LEN = 3'd1,
        HDR_PC  = 3'd2,
        LOAD    = 3'd3,
        RUN     = 3'd4,
        ERROR   = 3'd5
    } state_t;
    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 15;
    function automatic logic is_busy(state_t s);
        return s inside {HDR_LEN, HDR_PC, LOAD};
    endfunction
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream, instruction-memory write port and processor control of the loader.
interface imem_loader_if #(parameter int ADDR_W = 8);
    logic              load_start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [31:0]       start_pc;
    logic              proc_run;
    logic              busy;
    logic              err;
    modport master (
        output load_start, in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata, start_pc, proc_run, busy, err
    );
    modport slave (
        input  load_start, in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata, start_pc, proc_run, busy, err
    );
endinterface

// File: rtl/imem_loader_byte_packer32.sv
// byte_packer32: packs a byte stream MSB-first into 32-bit words, pulsing o_word_done on the 4th byte.
module byte_packer32 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_fire,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);
    logic [1:0]  r_cnt;
    logic [23:0] r_acc;
    // Only the three most recent bytes need storing; the 4th is the live input.
    assign o_word      = {r_acc, i_byte};
    assign o_word_done = i_fire && r_cnt == 2'd3;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_fire) begin
            r_cnt <= r_cnt + 2'd1;
            r_acc <= o_word[23:0];
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a length/PC header from a byte stream, writes the program into
// instruction memory, then releases the processor at start_pc.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    imem_loader_if.slave bus
);
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state, w_next;
    logic [ADDR_W:0]   r_len, r_wcnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_start_pc;
    logic              w_busy, w_run, w_err, w_fire, w_start, w_done, w_len_bad, w_last;
    logic [31:0]       w_word;
    logic [15:0]       w_len_field;

    assign w_fire      = bus.in_valid && w_busy;
    assign w_start     = bus.load_start && !w_busy;
    assign w_len_field = w_word[LEN_MSB:LEN_LSB];
    assign w_len_bad   = 17'(w_len_field) > 17'(CAP);
    assign w_last      = r_wcnt == r_len - 1'b1;

    byte_packer32 u_packer (
        .i_clk       (CLK),
        .i_rst_n     (RESET),
        .i_clr       (w_start),
        .i_fire      (w_fire),
        .i_byte      (bus.in_data),
        .o_word      (w_word),
        .o_word_done (w_done)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // The final word's strobe lands in the first RUN cycle, so release waits for it to clear.
    always_comb begin
        w_next = r_state;
        w_busy = is_busy(r_state);
        w_run  = r_state == RUN && !r_we;
        w_err  = r_state == ERROR;
        unique case (r_state)
            IDLE, RUN, ERROR: w_next = bus.load_start ? HDR_LEN : r_state;
            HDR_LEN:          w_next = w_done ? (w_len_bad ? ERROR : HDR_PC) : r_state;
            HDR_PC:           w_next = w_done ? (r_len == '0 ? RUN : LOAD) : r_state;
            LOAD:             w_next = (w_done && w_last) ? RUN : r_state;
            default:          w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_len      <= '0;
            r_wcnt     <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_start_pc <= '0;
        end else begin
            r_we <= 1'b0;
            if (r_state == HDR_LEN && w_done) r_len <= (ADDR_W+1)'(w_len_field);
            if (r_state == HDR_PC && w_done) begin
                r_start_pc <= w_word;
                r_wcnt     <= '0;
            end
            if (r_state == LOAD && w_done) begin
                r_we    <= 1'b1;
                r_addr  <= r_wcnt[ADDR_W-1:0];
                r_wdata <= w_word;
                r_wcnt  <= r_wcnt + 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_busy;
    assign bus.busy       = w_busy;
    assign bus.err        = w_err;
    assign bus.proc_run   = w_run;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.start_pc   = r_start_pc;
endmodule
